// File: rtl/tlb_ptw_if.sv
// Bus bundle of the Sv32 page-table walker: miss request/response,
// single-outstanding PTE read port and the TLB write port.
interface tlb_ptw_if;
    logic [21:0] satp_ppn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        resp_valid;
    logic        resp_fault;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        tlb_wr_en;
    logic [31:0] tlb_wr_vaddr;
    logic [31:0] tlb_wr_paddr;
    logic [2:0]  tlb_wr_perm;

    // Walker view.
    modport slave (
        input  satp_ppn, flush, req_valid, req_vaddr,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        output req_ready, resp_valid, resp_fault,
               mem_req_valid, mem_req_addr,
               tlb_wr_en, tlb_wr_vaddr, tlb_wr_paddr, tlb_wr_perm
    );

    // Requester / memory / TLB view.
    modport master (
        output satp_ppn, flush, req_valid, req_vaddr,
               mem_req_ready, mem_resp_valid, mem_resp_data,
        input  req_ready, resp_valid, resp_fault,
               mem_req_valid, mem_req_addr,
               tlb_wr_en, tlb_wr_vaddr, tlb_wr_paddr, tlb_wr_perm
    );
endinterface

// File: rtl/tlb_ptw.sv
// Sv32 two-level hardware page-table walker. Takes one TLB miss at a time,
// reads PTEs through a single-outstanding memory port, writes the TLB on a
// valid leaf and reports done/fault. A flush aborts the walk; a read already
// in flight is drained and discarded.
module tlb_ptw #(
    parameter int VPN_WIDTH = 20,
    parameter int PPN_WIDTH = 20
) (
    input  logic     clk,
    input  logic     rst_n,
    tlb_ptw_if.slave bus
);
    localparam int LVL_W = VPN_WIDTH / 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L0_REQ  = 3'd3,
        L0_WAIT = 3'd4,
        REFILL  = 3'd5,
        FAULT   = 3'd6,
        DRAIN   = 3'd7
    } state_e;

    state_e               state_q, state_d;
    logic [VPN_WIDTH-1:0] vpn_q, vpn_d;
    // Only the low 20 root bits survive the 32-bit PTE address truncation.
    logic [19:0]          root_q, root_d;
    // Holds the next-level table PPN while walking, then the leaf PPN.
    logic [PPN_WIDTH-1:0] ppn_q, ppn_d;
    logic [2:0]           perm_q, perm_d;

    logic [LVL_W-1:0] vpn1, vpn0;
    logic             pte_bad, pte_ptr, pte_misaligned;
    logic [31:0]      l1_addr, l0_addr;
    logic             wr_en;

    assign vpn1 = vpn_q[VPN_WIDTH-1:LVL_W];
    assign vpn0 = vpn_q[LVL_W-1:0];

    // PTE classification: bad = not valid, write-only, or PPN above 32-bit PA.
    assign pte_bad        = !bus.mem_resp_data[0]
                          || (!bus.mem_resp_data[1] && bus.mem_resp_data[2])
                          || (bus.mem_resp_data[31:30] != 2'b00);
    assign pte_ptr        = (bus.mem_resp_data[3:1] == 3'b000);
    assign pte_misaligned = (bus.mem_resp_data[10 +: LVL_W] != '0);

    assign l1_addr = {root_q, 12'b0} + 32'({vpn1, 2'b00});
    assign l0_addr = 32'({ppn_q, 12'b0}) + 32'({vpn0, 2'b00});

    // Moore outputs; flush masks the completion pulses of the final cycle.
    assign wr_en             = (state_q == REFILL) && !bus.flush;
    assign bus.req_ready     = (state_q == IDLE);
    assign bus.mem_req_valid = (state_q == L1_REQ) || (state_q == L0_REQ);
    assign bus.mem_req_addr  = (state_q == L1_REQ) ? l1_addr :
                               (state_q == L0_REQ) ? l0_addr : '0;
    assign bus.tlb_wr_en     = wr_en;
    assign bus.tlb_wr_vaddr  = wr_en ? 32'({vpn_q, 12'b0}) : '0;
    assign bus.tlb_wr_paddr  = wr_en ? 32'({ppn_q, 12'b0}) : '0;
    assign bus.tlb_wr_perm   = wr_en ? perm_q : '0;
    assign bus.resp_valid    = ((state_q == REFILL) || (state_q == FAULT)) && !bus.flush;
    assign bus.resp_fault    = (state_q == FAULT) && !bus.flush;

    // State and walk context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vpn_q   <= '0;
            root_q  <= '0;
            ppn_q   <= '0;
            perm_q  <= '0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            root_q  <= root_d;
            ppn_q   <= ppn_d;
            perm_q  <= perm_d;
        end
    end

    // Next-state: walk sequencing, PTE checks and flush abort handling.
    always_comb begin
        state_d = state_q;
        vpn_d   = vpn_q;
        root_d  = root_q;
        ppn_d   = ppn_q;
        perm_d  = perm_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    vpn_d   = bus.req_vaddr[31:32-VPN_WIDTH];
                    root_d  = bus.satp_ppn[19:0];
                    state_d = L1_REQ;
                end
            end
            L1_REQ, L0_REQ: begin
                // A read accepted in the flush cycle is still in flight.
                if (bus.mem_req_ready)
                    state_d = bus.flush ? DRAIN :
                              (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                else if (bus.flush)
                    state_d = IDLE;
            end
            L1_WAIT: begin
                if (bus.mem_resp_valid) begin
                    // Response landing with the flush leaves nothing to drain.
                    if (bus.flush)
                        state_d = IDLE;
                    else if (pte_bad)
                        state_d = FAULT;
                    else if (pte_ptr) begin
                        ppn_d   = bus.mem_resp_data[10 +: PPN_WIDTH];
                        state_d = L0_REQ;
                    end else if (pte_misaligned)
                        state_d = FAULT;
                    else begin
                        ppn_d   = {bus.mem_resp_data[20 +: PPN_WIDTH-LVL_W], vpn0};
                        perm_d  = bus.mem_resp_data[3:1];
                        state_d = REFILL;
                    end
                end else if (bus.flush)
                    state_d = DRAIN;
            end
            L0_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (bus.flush)
                        state_d = IDLE;
                    else if (pte_bad || pte_ptr)
                        state_d = FAULT;
                    else begin
                        ppn_d   = bus.mem_resp_data[10 +: PPN_WIDTH];
                        perm_d  = bus.mem_resp_data[3:1];
                        state_d = REFILL;
                    end
                end else if (bus.flush)
                    state_d = DRAIN;
            end
            REFILL, FAULT: state_d = IDLE;
            DRAIN: begin
                if (bus.mem_resp_valid)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_tlb_ptw.sv
// Bench for tlb_ptw: directed vector table (including flush aborts), a
// mid-walk reset sequence and randomized walks against a reference model.
module tb_tlb_ptw;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tlb_ptw_if bus();

    tlb_ptw #(.VPN_WIDTH(20), .PPN_WIDTH(20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          fault;
        int          reads;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [31:0] paddr;
        logic [2:0]  perm;
    } exp_t;

    typedef struct {
        logic [31:0] va;
        logic [21:0] satp;
        logic [31:0] l1;
        logic [31:0] l0;
        int          rdy;
        int          rsp;
        int          flush_cyc;
        bit          exp_resp;
        bit          exp_fault;
        logic [31:0] exp_paddr;
        logic [2:0]  exp_perm;
        int          exp_reads;
        int          exp_cyc;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: Sv32 rules in plain integer arithmetic.
    function automatic bit pte_ok(input longint unsigned p);
        return (p % 2 == 1) && ((p / 2) % 4 != 2) && (p / (64'd1 << 30) == 0);
    endfunction

    function automatic bit pte_leaf(input longint unsigned p);
        return ((p / 2) % 8) != 0;
    endfunction

    function automatic exp_t ref_walk(input logic [31:0] va, input logic [21:0] satp,
                                      input logic [31:0] l1, input logic [31:0] l0);
        exp_t e;
        longint unsigned lva, ls, p1, p0, vpn1, vpn0, a;
        lva = va; ls = satp; p1 = l1; p0 = l0;
        vpn1 = lva / (64'd1 << 22);
        vpn0 = (lva / 4096) % 1024;
        e.fault = 0; e.reads = 1; e.addr1 = 0; e.paddr = 0; e.perm = 0;
        a = (ls * 4096 + vpn1 * 4) % (64'd1 << 32);
        e.addr0 = a[31:0];
        if (!pte_ok(p1)) begin
            e.fault = 1;
        end else if (pte_leaf(p1)) begin
            if ((p1 / 1024) % 1024 != 0) e.fault = 1;
            else begin
                a = ((p1 / (64'd1 << 20)) % 1024) * (64'd1 << 22) + vpn0 * 4096;
                e.paddr = a[31:0];
                a = (p1 / 2) % 8;
                e.perm = a[2:0];
            end
        end else begin
            e.reads = 2;
            a = ((p1 / 1024) % (64'd1 << 20)) * 4096 + vpn0 * 4;
            e.addr1 = a[31:0];
            if (!pte_ok(p0) || !pte_leaf(p0)) e.fault = 1;
            else begin
                a = ((p0 / 1024) % (64'd1 << 20)) * 4096;
                e.paddr = a[31:0];
                a = (p0 / 2) % 8;
                e.perm = a[2:0];
            end
        end
        return e;
    endfunction

    function automatic vec_t mk(input logic [31:0] va, input logic [21:0] satp,
                                input logic [31:0] l1, input logic [31:0] l0,
                                input int rdy, input int rsp, input int fl,
                                input bit resp, input bit fault, input logic [31:0] pa,
                                input logic [2:0] perm, input int reads, input int cyc);
        vec_t v;
        v.va = va; v.satp = satp; v.l1 = l1; v.l0 = l0;
        v.rdy = rdy; v.rsp = rsp; v.flush_cyc = fl;
        v.exp_resp = resp; v.exp_fault = fault; v.exp_paddr = pa; v.exp_perm = perm;
        v.exp_reads = reads; v.exp_cyc = cyc;
        return v;
    endfunction

    function automatic logic [31:0] gen_pte();
        logic [31:0] r;
        logic [2:0]  ok_xwr [5];
        logic [2:0]  x;
        r = $urandom;
        ok_xwr = '{3'b001, 3'b011, 3'b100, 3'b101, 3'b111};
        x = ok_xwr[$urandom_range(4)];
        case ($urandom_range(5))
            0: return (r & 32'h3FFF_FFF0) | 32'h1;
            1: return (r & 32'h3FF0_03F0) | {28'b0, x, 1'b1};
            2: return (r & 32'h3FFF_FFF0) | {28'b0, x, 1'b1};
            3: return r & ~32'h1;
            4: return (r & 32'h3FFF_FFF0) | (r[31] ? 32'h5 : 32'hD);
            default: return r | 32'h4000_0003;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 0; bus.flush = 0; bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0; bus.mem_resp_data = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " req_ready"}, bus.req_ready, 1);
        check({tag, " outs_zero"}, |{bus.mem_req_valid, bus.resp_valid, bus.resp_fault,
              bus.tlb_wr_en, bus.mem_req_addr, bus.tlb_wr_vaddr, bus.tlb_wr_paddr,
              bus.tlb_wr_perm}, 0);
    endtask

    // Drives one walk cycle by cycle, acting as requester and PTE memory.
    task automatic run_walk(input string tag, input vec_t v, input bit noise);
        exp_t        m;
        int          reads, wr_cnt, wr_cyc, end_cyc, rdy_wait, rsp_wait, viol, addr_bad;
        bit          pend, resp, fault, done, stalled;
        logic [31:0] wr_va, wr_pa, last_addr;
        logic [2:0]  wr_perm;
        m = ref_walk(v.va, v.satp, v.l1, v.l0);
        reads = 0; wr_cnt = 0; wr_cyc = -1; end_cyc = -1; rdy_wait = 0; rsp_wait = 0;
        viol = 0; addr_bad = 0; pend = 0; resp = 0; fault = 0; done = 0; stalled = 0;
        wr_va = 0; wr_pa = 0; wr_perm = 0; last_addr = 0;
        @(negedge clk);
        idle_inputs();
        bus.req_valid = 1; bus.req_vaddr = v.va; bus.satp_ppn = v.satp;
        #1 check({tag, " accept"}, bus.req_ready, 1);
        for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
            @(negedge clk);
            bus.req_valid = 0; bus.req_vaddr = $urandom; bus.satp_ppn = 22'($urandom);
            bus.flush = (cyc == v.flush_cyc);
            bus.mem_req_ready = (rdy_wait >= v.rdy);
            if (pend) bus.mem_resp_valid = (rsp_wait >= v.rsp);
            else      bus.mem_resp_valid = noise && ($urandom_range(3) == 0);
            bus.mem_resp_data = (pend && bus.mem_resp_valid) ? ((reads == 1) ? v.l1 : v.l0) : $urandom;
            #1;
            if (bus.mem_req_valid && pend) viol++;
            if (stalled && (!bus.mem_req_valid || bus.mem_req_addr !== last_addr)) viol++;
            stalled = bus.mem_req_valid && !bus.mem_req_ready && !bus.flush;
            last_addr = bus.mem_req_addr;
            if (pend && bus.mem_resp_valid) pend = 0;
            else if (pend) rsp_wait++;
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                reads++;
                if (reads == 1 && bus.mem_req_addr !== m.addr0) addr_bad++;
                if (reads == 2 && bus.mem_req_addr !== m.addr1) addr_bad++;
                if (reads > 2) addr_bad++;
                pend = 1; rsp_wait = 0; rdy_wait = 0;
            end else if (bus.mem_req_valid) rdy_wait++;
            if (bus.tlb_wr_en) begin
                wr_cnt++; wr_cyc = cyc;
                wr_va = bus.tlb_wr_vaddr; wr_pa = bus.tlb_wr_paddr; wr_perm = bus.tlb_wr_perm;
            end
            if (bus.resp_valid) begin
                resp = 1; fault = bus.resp_fault; end_cyc = cyc; done = 1;
            end else if (v.flush_cyc >= 0 && cyc > v.flush_cyc && !pend && bus.req_ready) begin
                end_cyc = cyc; done = 1;
            end
        end
        idle_inputs();
        check({tag, " resp"}, resp, v.exp_resp);
        check({tag, " end_cycle"}, end_cyc, v.exp_cyc);
        check({tag, " reads"}, reads, v.exp_reads);
        check({tag, " pte_addr_errs"}, addr_bad, 0);
        check({tag, " mem_protocol_errs"}, viol, 0);
        if (v.exp_resp) begin
            check({tag, " fault"}, fault, v.exp_fault);
            check({tag, " tlb_writes"}, wr_cnt, v.exp_fault ? 0 : 1);
            if (!v.exp_fault) begin
                check({tag, " wr_cycle"}, wr_cyc, end_cyc);
                check({tag, " wr_vaddr"}, wr_va, v.va & 32'hFFFF_F000);
                check({tag, " wr_paddr"}, wr_pa, v.exp_paddr);
                check({tag, " wr_perm"}, wr_perm, v.exp_perm);
            end
        end else begin
            check({tag, " tlb_writes"}, wr_cnt, 0);
        end
    endtask

    initial begin
        vec_t tbl [14];
        vec_t rv;
        exp_t m;

        // L1 pointer 0x00080001 -> L0 table at 0x00200000; PPN fields are PTE[29:10].
        tbl[0]  = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h1234500F, 0, 0, -1, 1, 0, 32'h48D14000, 3'b111, 2, 5);
        tbl[1]  = mk(32'h00403ABC, 22'h100,    32'h2000000B, 32'h00000000, 0, 0, -1, 1, 0, 32'h80003000, 3'b101, 1, 3);
        tbl[2]  = mk(32'h00403ABC, 22'h100,    32'h2000040B, 32'h00000000, 0, 0, -1, 1, 1, 32'h0,        3'b000, 1, 3);
        tbl[3]  = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h00000000, 0, 0, -1, 1, 1, 32'h0,        3'b000, 2, 5);
        tbl[4]  = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h1234500F, 4, 0, -1, 1, 0, 32'h48D14000, 3'b111, 2, 13);
        tbl[5]  = mk(32'h00403ABC, 22'h100,    32'h00000005, 32'h00000000, 0, 0, -1, 1, 1, 32'h0,        3'b000, 1, 3);
        tbl[6]  = mk(32'h00403ABC, 22'h100,    32'h4000000F, 32'h00000000, 0, 0, -1, 1, 1, 32'h0,        3'b000, 1, 3);
        tbl[7]  = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h00000001, 0, 0, -1, 1, 1, 32'h0,        3'b000, 2, 5);
        tbl[8]  = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h1234500F, 0, 2, -1, 1, 0, 32'h48D14000, 3'b111, 2, 9);
        tbl[9]  = mk(32'hFFC01000, 22'h3FFFFF, 32'h0FF00007, 32'h00000000, 0, 0, -1, 1, 0, 32'h3FC01000, 3'b011, 1, 3);
        tbl[10] = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h1234500F, 0, 3,  7, 0, 0, 32'h0,        3'b000, 2, 11);
        tbl[11] = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h1234500F, 2, 0,  1, 0, 0, 32'h0,        3'b000, 0, 2);
        tbl[12] = mk(32'h00403ABC, 22'h100,    32'h00080001, 32'h1234500F, 0, 0,  1, 0, 0, 32'h0,        3'b000, 1, 3);
        tbl[13] = mk(32'h00403ABC, 22'h100,    32'h2000000B, 32'h00000000, 0, 0,  3, 0, 0, 32'h0,        3'b000, 1, 4);

        idle_inputs();
        bus.req_vaddr = 0; bus.satp_ppn = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 14; i++) run_walk($sformatf("vec%0d", i), tbl[i], 0);

        // Reset asserted while the L1 read is outstanding.
        @(negedge clk);
        idle_inputs();
        bus.req_valid = 1; bus.req_vaddr = 32'h00403ABC; bus.satp_ppn = 22'h100;
        bus.mem_req_ready = 1;
        @(negedge clk);
        bus.req_valid = 0;
        #1 check("midrst l1_req_valid", bus.mem_req_valid, 1);
        @(negedge clk);
        rst_n = 0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1;
        idle_inputs();
        run_walk("midrst_fresh", tbl[0], 0);

        // Randomized walks with random stalls and stray memory responses.
        for (int i = 0; i < 200; i++) begin
            rv.va = $urandom; rv.satp = 22'($urandom);
            rv.l1 = gen_pte(); rv.l0 = gen_pte();
            rv.rdy = $urandom_range(3); rv.rsp = $urandom_range(3); rv.flush_cyc = -1;
            m = ref_walk(rv.va, rv.satp, rv.l1, rv.l0);
            rv.exp_resp = 1; rv.exp_fault = m.fault; rv.exp_paddr = m.paddr; rv.exp_perm = m.perm;
            rv.exp_reads = m.reads; rv.exp_cyc = m.reads * (2 + rv.rdy + rv.rsp) + 1;
            run_walk($sformatf("rnd%0d", i), rv, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
